alu_seq_ctrl: RTL
=================

# alu_seq_ctrl

Multi-cycle sequencer for the lab's sign-magnitude calculator datapath. Accepts two 5-bit sign-magnitude operands and a 2-bit opcode on a start strobe. Runs add/sub in one execute cycle and multiply/divide as 4-step iterative shift-add / restoring-divide loops. Holds the 8-bit magnitude result and sign that feed the seven-segment display driver.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level, sampled only in IDLE; high at a clk edge launches an operation
- x  in  5  operand A; x[4] sign (1 = negative), x[3:0] magnitude
- y  in  5  operand B; same encoding
- op  in  2  00 add, 01 subtract (A−B), 10 multiply, 11 divide (A/B, quotient only)
- out  out  8  result magnitude, registered
- sign  out  1  result sign (1 = negative), registered
- busy  out  1  high while an operation is in flight (any state but IDLE)
- done  out  1  one-cycle pulse: out/sign/err just updated
- err  out  1  divide-by-zero flag for the last completed operation, registered

## Operation
- States: IDLE, ADDSUB, MUL, DIV, FIN.
- IDLE + start=1 at edge: latch x, y, op into internal regs; clear iteration count.
  - op=00/01 → ADDSUB.
  - op=10 → MUL.
  - op=11 with y[3:0]≠0 → DIV.
  - op=11 with y[3:0]=0 → FIN with div0 flag set.
- start while busy is ignored. Inputs x/y/op are not sampled after launch.
- ADDSUB (1 cycle): signed a=±xm, b=±ym (6-bit two's complement internally). r=a+b (op 00) or a−b (op 01). Store |r| (max 30) and neg=(r<0). → FIN.
- MUL (4 cycles): acc 8-bit starts 0; mcand = {4'b0,xm}, shifted left 1 per cycle; mplier = ym, shifted right 1 per cycle; add mcand to acc when mplier[0]=1. neg = xs^ys. After 4th cycle → FIN. Max 15×15 = 225, no overflow.
- DIV (4 cycles): restoring. Rem 5-bit starts 0. Each cycle, rem = {rem[3:0], dividend MSB}, dividend shifts left. If rem ≥ ym, subtract ym and shift 1 into quotient, else 0. neg = xs^ys. After 4th cycle → FIN. Remainder discarded.
- FIN (1 cycle): at its edge, out ← result magnitude zero-extended to 8 bits. sign ← neg AND (magnitude≠0); negative zero is never produced. err ← div0. done=1 for the following cycle. → IDLE.
- Divide by zero: out=0, sign=0, err=1.
- err clears on the next completed non-error operation.
- Negative-zero operands (sign=1, mag=0) are treated as zero.
- out/sign/err hold their values between operations; they change only at the FIN edge or on reset.

## Timing
- Reset (async, immediate): state=IDLE; out=0, sign=0, busy=0, done=0, err=0; internal regs cleared.
- Reset mid-operation: operation aborted, no done pulse, outputs go to reset values.
- Launch edge = E0. busy=1 from E0 until the FIN edge; busy=0 in the cycle done=1.
- Add/sub: FIN at E1; out valid and done=1 after E2.
- Mul/div: iterations at E1–E4; done after E5.
- Div by zero: FIN at E0+1; done after E1.
- If start is still high when back in IDLE, a new operation launches on the next edge. Back-to-back ops are allowed: done cycle, then relaunch.
- done is never high for more than one consecutive cycle.

## Test plan
- Reset, then x=+5 (00101), y=−9 (11001), op=00, start 1 cycle → done after E2; out=4, sign=1, err=0; busy high 2 cycles.
- x=+7, y=−8, op=01 → out=15, sign=0. Then x=+3, y=+3, op=01 → out=0, sign=0 (no negative zero).
- x=−15 (11111), y=+15, op=10 → done after E5, out=225, sign=1. Toggle x/y/op during busy: result unchanged. Pulse start during busy: no extra launch.
- x=+13, y=−4, op=11 → out=3, sign=1. Then x=−9, y=+0, op=11 → done after E1, out=0, sign=0, err=1. Next valid op clears err.
- Assert rst at E3 of a multiply: outputs immediately 0, busy=0, no done. Re-launch after release completes normally.
- Hold start high continuously with op=00 → launches every 3 cycles, with exactly one done pulse each.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer for the sign-magnitude calculator datapath.
// Add/sub run in one execute cycle. Multiply and divide run as 4-step shift-add and
// restoring-divide loops. A final FIN cycle commits the result to the display-facing
// registers.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   start  in   launch strobe, sampled only while idle
//   x, y   in   5-bit sign-magnitude operands ([4] sign, [3:0] magnitude)
//   op     in   00 add, 01 sub (x-y), 10 mul, 11 div (x/y, quotient)
//   out    out  8-bit result magnitude (registered)
//   sign   out  result sign (registered, never negative zero)
//   busy   out  high in every state except idle
//   done   out  one-cycle pulse after out/sign/err update
//   err    out  divide-by-zero flag of the last completed operation
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] x,
  input  logic [4:0] y,
  input  logic [1:0] op,
  output logic [7:0] out,
  output logic       sign,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {StIdle, StAddSub, StMul, StDiv, StFin} state_e;

  state_e     state_q, state_d;
  logic [3:0] am_q, am_d;        // operand A magnitude
  logic       as_q, as_d;        // operand A sign (negative zero folded to +0)
  logic [3:0] bm_q, bm_d;        // operand B magnitude, also the divisor
  logic       bs_q, bs_d;
  logic       sub_q, sub_d;
  logic [7:0] acc_q, acc_d;      // result magnitude: sum, product or quotient
  logic [7:0] mcand_q, mcand_d;
  logic [3:0] mplier_q, mplier_d;
  logic [3:0] rem_q, rem_d;      // remainder stays below the divisor, so 4 bits hold it
  logic [3:0] dvd_q, dvd_d;
  logic [1:0] cnt_q, cnt_d;
  logic       neg_q, neg_d;
  logic       div0_q, div0_d;
  logic [7:0] out_q, out_d;
  logic       sign_q, sign_d;
  logic       err_q, err_d;
  logic       done_q, done_d;

  // Operand signs with negative zero folded to positive zero.
  logic       xs_n, ys_n;
  assign xs_n = x[4] & (|x[3:0]);
  assign ys_n = y[4] & (|y[3:0]);

  // Add/sub datapath in 6-bit two's complement; |result| is at most 30.
  logic [5:0] a_s, b_s, r_s, r_abs;
  assign a_s   = as_q ? (6'd0 - {2'b00, am_q}) : {2'b00, am_q};
  assign b_s   = bs_q ? (6'd0 - {2'b00, bm_q}) : {2'b00, bm_q};
  assign r_s   = sub_q ? (a_s - b_s) : (a_s + b_s);
  assign r_abs = r_s[5] ? (6'd0 - r_s) : r_s;

  // Restoring-divide step: bring in the next dividend bit and trial-subtract.
  logic [4:0] rem_sh;
  logic       q_bit;
  assign rem_sh = {rem_q, dvd_q[3]};
  assign q_bit  = (rem_sh >= {1'b0, bm_q});

  always_comb begin
    state_d  = state_q;
    am_d     = am_q;
    as_d     = as_q;
    bm_d     = bm_q;
    bs_d     = bs_q;
    sub_d    = sub_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    out_d    = out_q;
    sign_d   = sign_q;
    err_d    = err_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          am_d     = x[3:0];
          as_d     = xs_n;
          bm_d     = y[3:0];
          bs_d     = ys_n;
          sub_d    = op[0];
          acc_d    = 8'd0;
          mcand_d  = {4'b0000, x[3:0]};
          mplier_d = y[3:0];
          rem_d    = 4'd0;
          dvd_d    = x[3:0];
          cnt_d    = 2'd0;
          neg_d    = xs_n ^ ys_n;
          div0_d   = 1'b0;
          unique case (op)
            2'b10: state_d = StMul;
            2'b11: begin
              if (y[3:0] == 4'd0) begin
                // acc is already cleared, so FIN commits out=0, sign=0.
                div0_d  = 1'b1;
                state_d = StFin;
              end else begin
                state_d = StDiv;
              end
            end
            default: state_d = StAddSub;
          endcase
        end
      end

      StAddSub: begin
        acc_d   = {2'b00, r_abs};
        neg_d   = r_s[5];
        state_d = StFin;
      end

      StMul: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = {mcand_q[6:0], 1'b0};
        mplier_d = {1'b0, mplier_q[3:1]};
        cnt_d    = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = StFin;
      end

      StDiv: begin
        // When q_bit is 0 the shifted remainder is below the divisor, so bit 4 is 0.
        rem_d = q_bit ? (rem_sh[3:0] - bm_q) : rem_sh[3:0];
        acc_d = {acc_q[6:0], q_bit};
        dvd_d = {dvd_q[2:0], 1'b0};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = StFin;
      end

      StFin: begin
        out_d   = acc_q;
        sign_d  = neg_q & (|acc_q);
        err_d   = div0_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      am_q     <= 4'd0;
      as_q     <= 1'b0;
      bm_q     <= 4'd0;
      bs_q     <= 1'b0;
      sub_q    <= 1'b0;
      acc_q    <= 8'd0;
      mcand_q  <= 8'd0;
      mplier_q <= 4'd0;
      rem_q    <= 4'd0;
      dvd_q    <= 4'd0;
      cnt_q    <= 2'd0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      out_q    <= 8'd0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      am_q     <= am_d;
      as_q     <= as_d;
      bm_q     <= bm_d;
      bs_q     <= bs_d;
      sub_q    <= sub_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      out_q    <= out_d;
      sign_q   <= sign_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign out  = out_q;
  assign sign = sign_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);

endmodule
